// File: rtl/instr_fetch_if.sv
// Fetch unit bus bundle: PC input, instruction memory port and decode output.
interface instr_fetch_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] pc_addr;
  logic              pc_valid;
  logic              pc_ready;
  logic              redirect;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_data;
  logic [ADDR_W-1:0] instr_addr;

  modport master (
    input  pc_addr, pc_valid, redirect,
    input  mem_ack, mem_rdata, instr_ready,
    output pc_ready, mem_req, mem_addr,
    output instr_valid, instr_data, instr_addr
  );

  modport slave (
    output pc_addr, pc_valid, redirect,
    output mem_ack, mem_rdata, instr_ready,
    input  pc_ready, mem_req, mem_addr,
    input  instr_valid, instr_data, instr_addr
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch front end: one outstanding memory read,
// small instruction FIFO toward decode, flush on PC redirect.
module instr_fetch #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  instr_fetch_if.master  bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN
  } state_t;

  state_t            state;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;

  logic valid;
  logic accept;
  logic push;
  logic pop;

  assign valid  = (count != '0);
  assign accept = bus.pc_valid && bus.pc_ready;
  assign push   = (state == REQ) && bus.mem_ack
               && !bus.redirect;
  assign pop    = valid && bus.instr_ready
               && !bus.redirect;

  assign bus.pc_ready = (state == IDLE)
                     && !bus.redirect
                     && (count < CW'(DEPTH));
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.instr_valid = valid;
  assign bus.instr_data  = data_q[rd_ptr];
  assign bus.instr_addr  = addr_q[rd_ptr];

  // A redirect without ack must still finish the
  // handshake, so the read is drained and dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            mem_addr_q <= bus.pc_addr;
            mem_req_q  <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            state     <= IDLE;
          end else if (bus.redirect) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          mem_req_q <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (bus.redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        addr_q[wr_ptr] <= mem_addr_q;
        data_q[wr_ptr] <= bus.mem_rdata;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case (1'b1)
        push && !pop: count <= count + CW'(1);
        pop && !push: count <= count - CW'(1);
        default:      count <= count;
      endcase
    end
  end
endmodule
